// File: rtl/mem_rd_arbiter.sv
// I/D read arbiter onto a single AXI3 AR/R master port, one transaction in flight.
// Define MEM_RD_ARB_ERR_EN to add sticky read-error capture (o_rd_err, o_rd_err_addr).
module mem_rd_arbiter #(
    parameter int         LINE_BYTE_OFFSET = 6,
    parameter int         D_STREAK_MAX     = 4,
    parameter logic [3:0] I_ARID           = 4'd0,
    parameter logic [3:0] D_ARID           = 4'd1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_i_req,
    input  logic [31:0] i_i_addr,
    input  logic [7:0]  i_i_len,
    input  logic [2:0]  i_i_size,
    output logic        o_i_gnt,
    output logic        o_i_rvalid,
    output logic        o_i_rlast,
    input  logic        i_d_req,
    input  logic [31:0] i_d_addr,
    input  logic [7:0]  i_d_len,
    input  logic [2:0]  i_d_size,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic        o_d_rlast,
    output logic [31:0] o_rdata,
`ifdef MEM_RD_ARB_ERR_EN
    output logic        o_rd_err,
    output logic [31:0] o_rd_err_addr,
`endif
    input  logic        i_wr_busy,
    input  logic [31:0] i_wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

    state_t      state;
    logic        owner_d;
    logic [3:0]  streak;
    logic        hazard;
    logic        d_ok;
    logic        i_force;
    logic        gnt_d;
    logic        gnt_i;
    logic        beat;

    assign hazard  = i_wr_busy &
                     (i_d_addr[31:LINE_BYTE_OFFSET] == i_wr_addr[31:LINE_BYTE_OFFSET]);
    assign d_ok    = i_d_req & ~hazard;
    // I is forced once D has won D_STREAK_MAX times in a row while I waited
    assign i_force = i_i_req & (streak == STREAK_MAX);
    assign gnt_d   = (state == IDLE) & d_ok & ~i_force;
    assign gnt_i   = (state == IDLE) & i_i_req & ~gnt_d;
    assign beat    = rvalid & rready;

    assign o_i_gnt    = gnt_i;
    assign o_d_gnt    = gnt_d;
    assign o_i_rvalid = rready & ~owner_d & rvalid;
    assign o_d_rvalid = rready & owner_d & rvalid;
    assign o_i_rlast  = rready & ~owner_d & rvalid & rlast;
    assign o_d_rlast  = rready & owner_d & rvalid & rlast;
    assign o_rdata    = rready ? rdata : 32'd0;

    assign arid    = owner_d ? D_ARID : I_ARID;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            streak  <= 4'd0;
            araddr  <= 32'd0;
            arlen   <= 8'd0;
            arsize  <= 3'd0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_d) begin
                        owner_d <= 1'b1;
                        araddr  <= i_d_addr;
                        arlen   <= i_d_len;
                        arsize  <= i_d_size;
                        arvalid <= 1'b1;
                        state   <= AR;
                        if (!i_i_req)
                            streak <= 4'd0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 4'd1;
                    end else if (gnt_i) begin
                        owner_d <= 1'b0;
                        araddr  <= i_i_addr;
                        arlen   <= i_i_len;
                        arsize  <= i_i_size;
                        arvalid <= 1'b1;
                        streak  <= 4'd0;
                        state   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (beat && rlast) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RD_ARB_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_err      <= 1'b0;
            o_rd_err_addr <= 32'd0;
        end else if (beat && (rresp != 2'b00) && !o_rd_err) begin
            o_rd_err      <= 1'b1;
            o_rd_err_addr <= araddr;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rid, i_wr_addr[LINE_BYTE_OFFSET-1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{rid, rresp, i_wr_addr[LINE_BYTE_OFFSET-1:0]};
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: grant order, routing, hazard, stall, reset.
// Error-capture checks are compiled when MEM_RD_ARB_ERR_EN is defined.
module tb_mem_rd_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_i_req, i_d_req;
    logic [31:0] i_i_addr, i_d_addr;
    logic [7:0]  i_i_len, i_d_len;
    logic [2:0]  i_i_size, i_d_size;
    logic        o_i_gnt, o_i_rvalid, o_i_rlast;
    logic        o_d_gnt, o_d_rvalid, o_d_rlast;
    logic [31:0] o_rdata;
`ifdef MEM_RD_ARB_ERR_EN
    logic        o_rd_err;
    logic [31:0] o_rd_err_addr;
`endif
    logic        i_wr_busy;
    logic [31:0] i_wr_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int n_chk = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    mem_rd_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_i_req(i_i_req), .i_i_addr(i_i_addr), .i_i_len(i_i_len),
        .i_i_size(i_i_size), .o_i_gnt(o_i_gnt), .o_i_rvalid(o_i_rvalid),
        .o_i_rlast(o_i_rlast),
        .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_len(i_d_len),
        .i_d_size(i_d_size), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid),
        .o_d_rlast(o_d_rlast),
        .o_rdata(o_rdata),
`ifdef MEM_RD_ARB_ERR_EN
        .o_rd_err(o_rd_err), .o_rd_err_addr(o_rd_err_addr),
`endif
        .i_wr_busy(i_wr_busy), .i_wr_addr(i_wr_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Entered 2 time units after an IDLE-cycle edge with requests applied.
    task automatic txn(input bit exp_d, input logic [31:0] exp_addr,
                       input int nbeats, input bit drop, input int err_beat);
        chk("gnt_i", o_i_gnt, !exp_d);
        chk("gnt_d", o_d_gnt, exp_d);
        step();
        if (drop) begin
            if (exp_d) i_d_req = 1'b0;
            else i_i_req = 1'b0;
        end
        #1;
        chk("ar_valid", arvalid, 1);
        chk("ar_id", arid, exp_d ? 32'd1 : 32'd0);
        chk("ar_addr", araddr, exp_addr);
        chk("ar_len", arlen, nbeats - 1);
        step();
        #1;
        chk("r_ready", rready, 1);
        chk("ar_drop", arvalid, 0);
        for (int b = 0; b < nbeats; b++) begin
            rvalid = 1'b1;
            rdata  = exp_addr + b;
            rlast  = (b == nbeats - 1);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            #1;
            chk("i_rvalid", o_i_rvalid, !exp_d);
            chk("d_rvalid", o_d_rvalid, exp_d);
            chk("rdata", o_rdata, exp_addr + b);
            chk("i_rlast", o_i_rlast, !exp_d && (b == nbeats - 1));
            chk("d_rlast", o_d_rlast, exp_d && (b == nbeats - 1));
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        #1;
        chk("idle_rready", rready, 0);
    endtask

    initial begin
        bit order [10];
        order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        i_rst_n = 1'b0;
        i_i_req = 1'b0; i_i_addr = '0; i_i_len = '0; i_i_size = 3'd2;
        i_d_req = 1'b0; i_d_addr = '0; i_d_len = '0; i_d_size = 3'd2;
        i_wr_busy = 1'b0; i_wr_addr = '0;
        arready = 1'b1; rid = '0; rdata = '0; rresp = '0;
        rlast = 1'b0; rvalid = 1'b0;
        repeat (2) step();
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_arburst", arburst, 1);
        chk("rst_araddr", araddr, 0);
        chk("rst_arid", arid, 0);
        chk("rst_arlock", arlock, 0);
        chk("rst_arcache", arcache, 0);
        chk("rst_arprot", arprot, 0);
`ifdef MEM_RD_ARB_ERR_EN
        chk("rst_err", o_rd_err, 0);
        chk("rst_err_addr", o_rd_err_addr, 0);
`endif
        step();
        i_rst_n = 1'b1;

        // I only, 16-beat refill
        step();
        i_i_req = 1'b1; i_i_addr = 32'h1FC0_0000; i_i_len = 8'd15;
        #1;
        txn(0, 32'h1FC0_0000, 16, 1, -1);

        // simultaneous: D first, then I right after D's rlast
        step();
        i_i_req = 1'b1; i_i_addr = 32'h100; i_i_len = 8'd1;
        i_d_req = 1'b1; i_d_addr = 32'h200; i_d_len = 8'd1;
        #1;
        txn(1, 32'h200, 2, 1, -1);
        txn(0, 32'h100, 2, 1, -1);

        // hazard blocks D but not I
        step();
        i_wr_busy = 1'b1; i_wr_addr = 32'h1040;
        i_d_req = 1'b1; i_d_addr = 32'h107C; i_d_len = 8'd0;
        i_i_req = 1'b1; i_i_addr = 32'h500; i_i_len = 8'd1;
        #1;
        txn(0, 32'h500, 2, 1, -1);
        chk("hz_block", o_d_gnt, 0);
        step();
        #1;
        chk("hz_block2", o_d_gnt, 0);
        step();
        i_wr_busy = 1'b0;
        #1;
        txn(1, 32'h107C, 1, 1, -1);

        // streak limit with both held
        step();
        i_d_req = 1'b1; i_d_addr = 32'h600; i_d_len = 8'd0;
        i_i_req = 1'b1; i_i_addr = 32'h700; i_i_len = 8'd0;
        #1;
        for (int k = 0; k < 10; k++)
            txn(order[k], order[k] ? 32'h600 : 32'h700, 1, 0, -1);
        i_i_req = 1'b0;
        i_d_req = 1'b0;

        // AR stall, then reset mid-burst
        step();
        arready = 1'b0;
        i_d_req = 1'b1; i_d_addr = 32'h3000; i_d_len = 8'd1;
        #1;
        chk("st_gnt", o_d_gnt, 1);
        step();
        i_d_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_arvalid", arvalid, 1);
            chk("st_araddr", araddr, 32'h3000);
            chk("st_arlen", arlen, 1);
            step();
        end
        arready = 1'b1;
        step();
        rvalid = 1'b1; rdata = 32'hABCD; rlast = 1'b0;
        #1;
        chk("st_rvalid", o_d_rvalid, 1);
        i_rst_n = 1'b0;
        #1;
        chk("mr_arvalid", arvalid, 0);
        chk("mr_rready", rready, 0);
        chk("mr_drvalid", o_d_rvalid, 0);
        rvalid = 1'b0;
        step();
        i_rst_n = 1'b1;
        step();
        #1;
        chk("mr_idle_arvalid", arvalid, 0);

`ifdef MEM_RD_ARB_ERR_EN
        step();
        i_d_req = 1'b1; i_d_addr = 32'h2000; i_d_len = 8'd3;
        #1;
        txn(1, 32'h2000, 4, 1, 2);
        chk("err_flag", o_rd_err, 1);
        chk("err_addr", o_rd_err_addr, 32'h2000);
        step();
        i_d_req = 1'b1; i_d_addr = 32'h4000; i_d_len = 8'd1;
        #1;
        txn(1, 32'h4000, 2, 1, -1);
        chk("err_keep", o_rd_err, 1);
        chk("err_addr_keep", o_rd_err_addr, 32'h2000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
